imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the instruction memory size in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a program load.
REQ-005 SHALL have port word_count, input, 11 bits: number of words to load, sampled when start is accepted.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid program byte.
REQ-007 SHALL have port byte_data, input, 8 bits: program byte stream, big-endian within each word.
REQ-008 SHALL have port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port imem_we, output, 1 bit: instruction memory write strobe.
REQ-010 SHALL have port imem_addr, output, 32 bits: byte address, always word-aligned; memory index is imem_addr>>2.
REQ-011 SHALL have port imem_wdata, output, 32 bits: assembled instruction word.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port cpu_hold, output, 1 bit: holds the pipeline PC/fetch while memory is being written.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when the load completes.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-016 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-017 In IDLE, start=1 with 1 <= word_count <= DEPTH SHALL latch word_count, clear the byte index, word counter and address to 0, set busy=cpu_hold=1, and go to RECV next cycle.
REQ-018 In IDLE, start=1 with word_count=0 or word_count>DEPTH SHALL pulse err for exactly one cycle and remain in IDLE; busy stays 0.
REQ-019 start SHALL be ignored in every state except IDLE.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte is accepted only on the cycle byte_valid=1 and byte_ready=1.
REQ-021 Accepted bytes SHALL fill the word in this order: byte 0 to bits [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0]; the 2-bit byte index wraps 3 to 0.
REQ-022 Acceptance of byte 3 SHALL move the block to WRITE on the next cycle; byte_valid=0 in RECV SHALL hold all state.
REQ-023 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=4*word index, and imem_wdata=the assembled word.
REQ-024 After WRITE, imem_addr SHALL advance by 4 and the word counter by 1; the block SHALL go to DONE if the counter equals the latched count, otherwise to RECV.
REQ-025 imem_addr SHALL never exceed 4*(DEPTH-1); there is no wrap, guaranteed by REQ-018.
REQ-026 DONE SHALL last one cycle with done=1 and busy=cpu_hold=0, then go to IDLE.
REQ-027 Minimum throughput SHALL be 5 cycles per word (4 accept cycles plus 1 write cycle).
REQ-028 imem_we SHALL be 0 in all states other than WRITE; imem_addr and imem_wdata are don't-care when imem_we=0 but SHALL be stable during WRITE.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, and set byte_ready, imem_we, busy, cpu_hold, done and err to 0, imem_addr and imem_wdata to 0, and all counters to 0.
REQ-030 Reset mid-load SHALL discard any partially assembled word with no write issued; words already written are not undone.
REQ-031 While rst_n=0, start SHALL be ignored.

Verification
REQ-032 The bench SHALL cover: word_count=2, bytes 01 09 58 20 AC 0B 00 00 streamed with no gaps -> writes of 0x01095820 at address 0 and 0xAC0B0000 at address 4, done pulse in cycle 11 after start acceptance, then busy=0.
REQ-033 The bench SHALL cover: word_count=1 with byte_valid toggling 1/0 each cycle, bytes 11 88 FF FE -> a single write of 0x1188FFFE at address 0, with cpu_hold=1 throughout.
REQ-034 The bench SHALL cover: start with word_count=0 and with word_count=1025 -> each gives a one-cycle err pulse, no imem_we, and busy=0.
REQ-035 The bench SHALL cover: word_count=1024 full load -> the last write is at address 0xFFC, followed by done, with exactly 1024 imem_we pulses.
REQ-036 The bench SHALL cover: rst_n=0 after 2 bytes of word 1 (during a word_count=3 load) -> no further imem_we, all outputs 0; a new start then writes from address 0.
REQ-037 The bench SHALL cover: start reasserted while busy -> ignored, and the word counter and address are unaffected.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams big-endian program bytes into instruction memory one word at a time,
// holding the CPU fetch while a load is in progress.
module imem_loader #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [10:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    state_t      state_q;
    logic [1:0]  idx_q;
    logic [10:0] count_q, words_q;
    logic [31:0] addr_q, word_q;
    logic        ready_q, we_q, busy_q, done_q, err_q;
    logic        bad_count, last_word;
    assign bad_count  = word_count == 11'd0 || {21'd0, word_count} > DEPTH_U;
    assign last_word  = words_q + 11'd1 == count_q;
    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_q;
    assign busy       = busy_q;
    assign cpu_hold   = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            count_q <= 11'd0;
            words_q <= 11'd0;
            addr_q  <= 32'd0;
            word_q  <= 32'd0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    if (bad_count) err_q <= 1'b1;
                    else begin
                        count_q <= word_count;
                        idx_q   <= 2'd0;
                        words_q <= 11'd0;
                        addr_q  <= 32'd0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= RECV;
                    end
                end
                RECV: if (byte_valid) begin
                    // shifting in MSB-first leaves byte 0 in [31:24] after four bytes
                    word_q <= {word_q[23:0], byte_data};
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    words_q <= words_q + 11'd1;
                    if (last_word) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        addr_q  <= addr_q + 32'd4;
                        ready_q <= 1'b1;
                        state_q <= RECV;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked by a write scoreboard fed from a byte-level model.
module tb_imem_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
    logic [10:0] word_count = 11'd0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, imem_we, busy, cpu_hold, done, err;
    logic [31:0] imem_addr, imem_wdata;
    typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
    wr_t        sb[$];
    wr_t        e;
    logic [7:0] bytes[$];
    int tests = 0, fails = 0, exp_err = 0, exp_done = 0;
    int n_we = 0, n_done = 0, cyc = 0, done_cyc = 0, hold_bad = 0;
    logic [31:0] last_addr = 32'd0;

    imem_loader #(.DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // monitor: every write, done and err is matched against what the stimulus predicted
    always @(negedge clk) if (rst_n) begin
        if (imem_we) begin
            n_we++;
            last_addr = imem_addr;
            if (sb.size() == 0) chk("unexpected_write", 1, 0);
            else begin
                e = sb.pop_front();
                chk("wr_addr", imem_addr, e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
            chk("hold_during_write", {busy, cpu_hold}, 2'b11);
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            chk("done_expected", exp_done > 0, 1);
            if (exp_done > 0) exp_done--;
            chk("done_all_written", sb.size(), 0);
            chk("done_flags", {busy, cpu_hold}, 2'b00);
        end
        if (err) begin
            chk("err_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
            chk("err_busy", busy, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_flags"}, {byte_ready, imem_we, busy, cpu_hold, done, err}, 0);
        chk({nm, "_addr"}, imem_addr, 0);
        chk({nm, "_wdata"}, imem_wdata, 0);
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        word_count = 11'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic rand_bytes(input int nw);
        bytes.delete();
        for (int i = 0; i < nw * 4; i++) bytes.push_back(8'($urandom));
    endtask

    // reference: word w is bytes 4w..4w+3 big-endian, stored at byte address 4w
    task automatic expect_words(input int nw);
        for (int w = 0; w < nw; w++)
            sb.push_back('{32'(4 * w), {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]}});
    endtask

    // mode 0: no gaps, 1: random gaps, 2: valid toggles each cycle; poke re-asserts start mid-load
    task automatic send(input int nb, input int mode, input bit poke);
        int i = 0, g = 0;
        bit acc;
        while (i < nb && g < nb * 8 + 100) begin
            byte_valid = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(g % 2 == 0);
            byte_data = bytes[i];
            start = poke && i == 5;
            if (poke) word_count = 11'd5;
            if (!cpu_hold) hold_bad++;
            acc = byte_valid && byte_ready;
            tick();
            g++;
            if (acc) i++;
        end
        byte_valid = 1'b0;
        start = 1'b0;
        if (i < nb) chk("byte_timeout", i, nb);
    endtask

    task automatic wait_done(input int tgt);
        int g = 0;
        while (n_done < tgt && g < 50) begin
            tick();
            g++;
        end
        chk("done_seen", n_done, tgt);
    endtask

    task automatic load(input int nw, input int mode, input bit poke);
        int tgt;
        tgt = n_done + 1;
        exp_done++;
        expect_words(nw);
        do_start(nw);
        chk("busy_after_start", {busy, cpu_hold}, 2'b11);
        send(nw * 4, mode, poke);
        wait_done(tgt);
        tick();
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        int we0, sc;
        repeat (2) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        bytes = '{8'h01, 8'h09, 8'h58, 8'h20, 8'hAC, 8'h0B, 8'h00, 8'h00};
        exp_done++;
        expect_words(2);
        do_start(2);
        sc = cyc;
        send(8, 0, 1'b0);
        wait_done(n_done + 1);
        chk("done_latency", done_cyc - sc, 10);
        tick();
        chk("busy_after_032", busy, 0);

        bytes = '{8'h11, 8'h88, 8'hFF, 8'hFE};
        hold_bad = 0;
        load(1, 2, 1'b0);
        chk("cpu_hold_throughout", hold_bad, 0);

        for (int k = 0; k < 2; k++) begin
            we0 = n_we;
            exp_err++;
            do_start(k == 0 ? 0 : 1025);
            repeat (3) tick();
            chk("err_pulse", exp_err, 0);
            chk("err_no_busy", busy, 0);
            chk("err_no_write", n_we, we0);
        end

        rand_bytes(1024);
        we0 = n_we;
        load(1024, 0, 1'b0);
        chk("full_we_count", n_we - we0, 1024);
        chk("full_last_addr", last_addr, 32'hFFC);

        rand_bytes(3);
        expect_words(1);
        do_start(3);
        send(6, 1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_zero("midload_reset");
        start = 1'b1;
        word_count = 11'd3;
        tick();
        chk("start_in_reset", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) tick();
        chk("reset_no_more_writes", sb.size(), 0);
        chk("reset_idle", busy, 0);

        rand_bytes(3);
        load(3, 1, 1'b1);

        for (int k = 0; k < 5; k++) begin
            int n;
            n = $urandom_range(1, 6);
            rand_bytes(n);
            load(n, $urandom_range(0, 1), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
